// File: rtl/page_table_walker.sv
// ---------------------------------------------------------------------------
// page_table_walker
//   Hardware page-table walker serving TLB misses. A miss request latches its
//   VA, PCID and the root table base, then walks LEVELS levels of 9-bit-indexed
//   tables with one PTE read outstanding at a time. The result (PPN or fault)
//   is offered to the TLB as a refill.
//
//   Optional feature (compile-time macro PTW_SUPERPAGE_EN):
//     defined   : a present PTE with PS=1 above level 0 is a superpage leaf.
//     undefined : a present PTE with PS=1 above level 0 faults.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   ptbr                 root table base (page aligned), sampled at accept
//   req_valid/req_ready  miss request handshake; req_va, req_pcid
//   mem_rd_valid/ready   PTE read request; mem_rd_addr = PTE byte address
//   mem_rsp_valid/data   PTE return (single-cycle pulse)
//   fill_valid/ready     refill handshake; fill_vpn, fill_pcid, fill_ppn,
//                        fill_fault
// ---------------------------------------------------------------------------
module page_table_walker #(
  parameter int ADDR   = 64,
  parameter int PAGE   = 12,
  parameter int PCID_B = 12,
  parameter int LEVELS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR-1:0]      ptbr,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR-1:0]      req_va,
  input  logic [PCID_B-1:0]    req_pcid,
  output logic                 mem_rd_valid,
  input  logic                 mem_rd_ready,
  output logic [ADDR-1:0]      mem_rd_addr,
  input  logic                 mem_rsp_valid,
  input  logic [63:0]          mem_rsp_data,
  output logic                 fill_valid,
  input  logic                 fill_ready,
  output logic [ADDR-PAGE-1:0] fill_vpn,
  output logic [PCID_B-1:0]    fill_pcid,
  output logic [ADDR-PAGE-1:0] fill_ppn,
  output logic                 fill_fault
);

  localparam int VPN_W = ADDR - PAGE;
  localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_REQ  = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] FILL    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [VPN_W-1:0]  table_ppn_q, table_ppn_d;
  logic [ADDR-1:0]   va_q, va_d;
  logic [PCID_B-1:0] pcid_q, pcid_d;
  logic [VPN_W-1:0]  ppn_q, ppn_d;
  logic              fault_q, fault_d;

  logic [8:0]        idx;
  logic [ADDR-1:0]   rd_addr;
  logic [VPN_W-1:0]  pte_ppn;
  logic              pte_present;
  logic              pte_ps;
  logic              unused_bits;

`ifdef PTW_SUPERPAGE_EN
  // Upper PPN bits come from the PTE, the low 9*lvl bits pass through from VA.
  function automatic logic [VPN_W-1:0] sp_ppn(input logic [VPN_W-1:0] pte_pn,
                                               input logic [ADDR-1:0]  va,
                                               input logic [LVL_W-1:0] lvl);
    logic [VPN_W-1:0] mask;
    mask = ~({VPN_W{1'b1}} << (9 * int'(lvl)));
    return (pte_pn & ~mask) | (va[ADDR-1:PAGE] & mask);
  endfunction
`endif

  assign pte_ppn     = mem_rsp_data[ADDR-1:PAGE];
  assign pte_present = mem_rsp_data[0];
  assign pte_ps      = mem_rsp_data[7];
  // Only the PPN, present and PS fields of a PTE are consumed.
  assign unused_bits = ^{mem_rsp_data, ptbr[PAGE-1:0]};

  always_comb begin
    idx     = 9'(va_q >> (PAGE + 9 * int'(level_q)));
    rd_addr = {table_ppn_q, {PAGE{1'b0}}} + {{(ADDR-12){1'b0}}, idx, 3'b000};
  end

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    table_ppn_d = table_ppn_q;
    va_d        = va_q;
    pcid_d      = pcid_q;
    ppn_d       = ppn_q;
    fault_d     = fault_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          va_d        = req_va;
          pcid_d      = req_pcid;
          table_ppn_d = ptbr[ADDR-1:PAGE];
          level_d     = LVL_W'(LEVELS - 1);
          state_d     = RD_REQ;
        end
      end
      RD_REQ: begin
        if (mem_rd_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rsp_valid) begin
          if (!pte_present) begin
            fault_d = 1'b1;
            ppn_d   = '0;
            state_d = FILL;
          end else if (level_q == '0) begin
            // PS is meaningless at the last level; the PTE is always a leaf.
            fault_d = 1'b0;
            ppn_d   = pte_ppn;
            state_d = FILL;
          end else if (pte_ps) begin
`ifdef PTW_SUPERPAGE_EN
            fault_d = 1'b0;
            ppn_d   = sp_ppn(pte_ppn, va_q, level_q);
`else
            fault_d = 1'b1;
            ppn_d   = '0;
`endif
            state_d = FILL;
          end else begin
            table_ppn_d = pte_ppn;
            level_d     = level_q - 1'b1;
            state_d     = RD_REQ;
          end
        end
      end
      default: begin
        if (fill_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      level_q     <= '0;
      table_ppn_q <= '0;
      va_q        <= '0;
      pcid_q      <= '0;
      ppn_q       <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      table_ppn_q <= table_ppn_d;
      va_q        <= va_d;
      pcid_q      <= pcid_d;
      ppn_q       <= ppn_d;
      fault_q     <= fault_d;
    end
  end

  // Address depends only on registers that are frozen in RD_REQ, so it is
  // stable across read backpressure.
  assign req_ready    = (state_q == IDLE);
  assign mem_rd_valid = (state_q == RD_REQ);
  assign mem_rd_addr  = mem_rd_valid ? rd_addr : '0;
  assign fill_valid   = (state_q == FILL);
  assign fill_vpn     = va_q[ADDR-1:PAGE];
  assign fill_pcid    = pcid_q;
  assign fill_ppn     = ppn_q;
  assign fill_fault   = fault_q;

endmodule

// File: tb/tb_page_table_walker.sv
module tb_page_table_walker;

  localparam int LEVELS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] ptbr;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_va;
  logic [11:0] req_pcid;
  logic        mem_rd_valid;
  logic        mem_rd_ready;
  logic [63:0] mem_rd_addr;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        fill_valid;
  logic        fill_ready;
  logic [51:0] fill_vpn;
  logic [11:0] fill_pcid;
  logic [51:0] fill_ppn;
  logic        fill_fault;

  page_table_walker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ptbr         (ptbr),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_va       (req_va),
    .req_pcid     (req_pcid),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_ready (mem_rd_ready),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .fill_valid   (fill_valid),
    .fill_ready   (fill_ready),
    .fill_vpn     (fill_vpn),
    .fill_pcid    (fill_pcid),
    .fill_ppn     (fill_ppn),
    .fill_fault   (fill_fault)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Page-table memory; missing entries read as 0 unless auto_fill invents them.
  logic [63:0] pmem [logic [63:0]];
  bit          auto_fill = 1'b0;

  // Reference results
  logic [63:0] exp_q[$];
  logic [51:0] exp_ppn;
  logic        exp_fault;

  // Last observed walk
  logic [51:0] last_ppn;
  logic        last_fault;
  int          last_cyc;
  int          last_nrd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] fetch(input logic [63:0] a);
    logic [63:0] p;
    int r;
    if (pmem.exists(a)) return pmem[a];
    if (!auto_fill) return 64'h0;
    r = int'($urandom_range(0, 99));
    p = {$urandom, $urandom} & ~64'hFFF;
    if (r < 10) begin
      p[7] = 1'($urandom);
    end else if (r < 25) begin
      p[0] = 1'b1;
      p[7] = 1'b1;
    end else begin
      p[0] = 1'b1;
    end
    pmem[a] = p;
    return p;
  endfunction

  // Walk the tables arithmetically: base + index*8 per level.
  task automatic model_walk(input logic [63:0] pt, input logic [63:0] va);
    logic [63:0] tbl, a, pte, lowmask;
    exp_q.delete();
    tbl = pt >> 12;
    for (int l = LEVELS - 1; l >= 0; l--) begin
      a = (tbl << 12) + (((va >> (12 + 9 * l)) & 64'h1FF) << 3);
      exp_q.push_back(a);
      pte = fetch(a);
      if (pte[0] == 1'b0) begin
        exp_fault = 1'b1; exp_ppn = '0; return;
      end
      if (l == 0) begin
        exp_fault = 1'b0; exp_ppn = 52'(pte >> 12); return;
      end
      if (pte[7]) begin
`ifdef PTW_SUPERPAGE_EN
        lowmask   = (64'd1 << (9 * l)) - 64'd1;
        exp_fault = 1'b0;
        exp_ppn   = 52'(((pte >> 12) & ~lowmask) | ((va >> 12) & lowmask));
`else
        lowmask   = 64'd0;
        exp_fault = 1'b1;
        exp_ppn   = '0;
`endif
        return;
      end
      tbl = pte >> 12;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_rd_valid"},  64'(mem_rd_valid), 64'd0);
    chk({tag, "_rd_addr"},   mem_rd_addr, 64'd0);
    chk({tag, "_fill_valid"}, 64'(fill_valid), 64'd0);
    chk({tag, "_fill_vpn"},  64'(fill_vpn), 64'd0);
    chk({tag, "_fill_pcid"}, 64'(fill_pcid), 64'd0);
    chk({tag, "_fill_ppn"},  64'(fill_ppn), 64'd0);
    chk({tag, "_fill_fault"}, 64'(fill_fault), 64'd0);
  endtask

  // Runs one walk from the post-edge point with the given backpressure.
  task automatic do_walk(input logic [63:0] pt, input logic [63:0] va, input logic [11:0] pcid,
                         input int rd_stall, input int lat, input int fl_stall, input string tag);
    logic [63:0]  got_q[$];
    logic [63:0]  a0, pend_addr;
    logic [116:0] fl_snap;
    int cyc, rd_left, fl_left, pend, unstable, busy_ready, w, exp_cyc;
    bit rd_seen, fl_seen, done;
    cyc = 0; rd_left = rd_stall; fl_left = fl_stall; pend = -1;
    unstable = 0; busy_ready = 0; rd_seen = 0; fl_seen = 0; done = 0;
    a0 = '0; pend_addr = '0; fl_snap = '0;
    req_valid = 1'b1; req_va = va; req_pcid = pcid; ptbr = pt;
    w = 0;
    while (!req_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (!req_ready) begin
      chk({tag, "_accept_timeout"}, 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Scramble the request inputs: the walker must work from latched copies.
    req_valid = 1'b0;
    ptbr      = {$urandom, $urandom} & ~64'hFFF;
    req_va    = {$urandom, $urandom};
    req_pcid  = 12'($urandom);
    while (!done && cyc < 400) begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = {$urandom, $urandom};
      mem_rd_ready  = 1'b0;
      fill_ready    = 1'b0;
      if (req_ready) busy_ready++;
      if (pend >= 0) begin
        if (pend == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = fetch(pend_addr);
        end
        pend--;
      end
      if (mem_rd_valid) begin
        if (!rd_seen) begin rd_seen = 1'b1; a0 = mem_rd_addr; end
        else if (mem_rd_addr !== a0) unstable++;
        if (rd_left > 0) begin
          rd_left--;
          // Stray present-leaf response outside RD_WAIT; must be dropped.
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = 64'hABC001;
        end else begin
          mem_rd_ready = 1'b1;
          got_q.push_back(a0);
          pend_addr = a0; pend = lat; rd_seen = 1'b0; rd_left = rd_stall;
        end
      end
      if (fill_valid) begin
        if (!fl_seen) begin fl_seen = 1'b1; fl_snap = {fill_vpn, fill_pcid, fill_ppn, fill_fault}; end
        else if ({fill_vpn, fill_pcid, fill_ppn, fill_fault} !== fl_snap) unstable++;
        if (fl_left > 0) begin
          fl_left--;
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = 64'hDEF001;
        end else begin
          fill_ready = 1'b1;
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    mem_rsp_valid = 1'b0;
    mem_rd_ready  = 1'b0;
    fill_ready    = 1'b0;
    last_cyc   = cyc;
    last_nrd   = got_q.size();
    last_ppn   = fl_snap[52:1];
    last_fault = fl_snap[0];

    model_walk(pt, va);
    exp_cyc = exp_q.size() * (2 + rd_stall + lat) + 1 + fl_stall;
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_nreads"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk({tag, "_rdaddr"}, (i < got_q.size()) ? got_q[i] : 64'hBAD0BAD0BAD0BAD0, exp_q[i]);
    chk({tag, "_ppn"},   64'(fl_snap[52:1]), 64'(exp_ppn));
    chk({tag, "_fault"}, 64'(fl_snap[0]), 64'(exp_fault));
    chk({tag, "_vpn"},   64'(fl_snap[116:65]), va >> 12);
    chk({tag, "_pcid"},  64'(fl_snap[64:53]), 64'(pcid));
    chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_stable"}, 64'(unstable), 64'd0);
    chk({tag, "_busy_ready"}, 64'(busy_ready), 64'd0);
    chk({tag, "_ready_after"}, 64'(req_ready), 64'd1);
    chk({tag, "_fill_after"}, 64'(fill_valid), 64'd0);
  endtask

  task automatic load_directed();
    pmem.delete();
    pmem[64'h1000] = 64'h2001;
    pmem[64'h2000] = 64'h3001;
    pmem[64'h3010] = 64'h4001;
    pmem[64'h4018] = 64'h99001;
  endtask

  initial begin : main
    int bad;
    rst_n = 1'b0; ptbr = '0; req_valid = 1'b0; req_va = '0; req_pcid = '0;
    mem_rd_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; fill_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("reset");

    // Full 4-level walk
    load_directed();
    do_walk(64'h1000, 64'h403ABC, 12'h5A, 0, 0, 0, "walk4");
    chk("walk4_ppn_const", 64'(last_ppn), 64'h99);
    chk("walk4_fault_const", 64'(last_fault), 64'd0);
    chk("walk4_cyc_const", 64'(last_cyc), 64'd9);
    chk("walk4_nrd_const", 64'(last_nrd), 64'd4);

    // Non-present at level 1
    pmem[64'h3010] = 64'h4000;
    do_walk(64'h1000, 64'h403ABC, 12'h11, 0, 0, 0, "nonpres");
    chk("nonpres_fault_const", 64'(last_fault), 64'd1);
    chk("nonpres_nrd_const", 64'(last_nrd), 64'd3);

    // Superpage at level 1
    pmem[64'h3010] = 64'h200081;
    do_walk(64'h1000, 64'h403ABC, 12'h22, 0, 0, 0, "super");
`ifdef PTW_SUPERPAGE_EN
    chk("super_ppn_const", 64'(last_ppn), 64'h203);
    chk("super_fault_const", 64'(last_fault), 64'd0);
`else
    chk("super_ppn_const", 64'(last_ppn), 64'h0);
    chk("super_fault_const", 64'(last_fault), 64'd1);
`endif
    chk("super_nrd_const", 64'(last_nrd), 64'd3);

    // Backpressure and memory latency
    load_directed();
    do_walk(64'h1000, 64'h403ABC, 12'h33, 5, 0, 3, "bp");
    do_walk(64'h1000, 64'h403ABC, 12'h44, 1, 2, 1, "lat");

    // Reset while a read is outstanding, then a late response
    req_valid = 1'b1; req_va = 64'h403ABC; req_pcid = 12'h77; ptbr = 64'h1000;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_rd_ready = 1'b1;
    chk("rstmid_rd_valid", 64'(mem_rd_valid), 64'd1);
    @(posedge clk); #1;
    mem_rd_ready = 1'b0;
    chk("rstmid_in_wait", 64'(mem_rd_valid), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_async_idle", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h99001;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      if (fill_valid || mem_rd_valid) bad++;
    end
    chk("rstmid_no_activity", 64'(bad), 64'd0);
    check_idle_outputs("rstmid");

    // Randomized walks over invented tables
    auto_fill = 1'b1;
    for (int t = 0; t < 40; t++) begin
      pmem.delete();
      do_walk({$urandom, $urandom} & ~64'hFFF, {$urandom, $urandom}, 12'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
              "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/page_table_walker.md
PAGE_TABLE_WALKER -- requirements
Module: page_table_walker

Interface
REQ-001 SHALL have parameter ADDR, default 64, meaning virtual/physical address width in bits.
REQ-002 SHALL have parameter PAGE, default 12, meaning page-offset width in bits.
REQ-003 SHALL have parameter PCID_B, default 12, meaning PCID width in bits.
REQ-004 SHALL have parameter LEVELS, default 4, meaning page-table depth (9 index bits per level).
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ptbr  in  ADDR  root table base, page aligned; sampled at request accept.
- req_valid  in  1  TLB miss request.
- req_ready  out  1  walker can accept a request.
- req_va  in  ADDR  missing virtual address.
- req_pcid  in  PCID_B  PCID of the request.
- mem_rd_valid  out  1  PTE read request.
- mem_rd_ready  in  1  memory accepts the read.
- mem_rd_addr  out  ADDR  PTE byte address.
- mem_rsp_valid  in  1  PTE data returned (one cycle pulse).
- mem_rsp_data  in  64  PTE.
- fill_valid  out  1  refill result to TLB.
- fill_ready  in  1  TLB accepts the refill.
- fill_vpn  out  ADDR-PAGE  req_va[ADDR-1:PAGE] of the walk.
- fill_pcid  out  PCID_B  PCID of the walk.
- fill_ppn  out  ADDR-PAGE  translated physical page number.
- fill_fault  out  1  walk failed; fill_ppn is 0.

Function
REQ-006 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, FILL.
REQ-007 SHALL assert req_ready only in IDLE; accept on req_valid&&req_ready, latch req_va, req_pcid, ptbr[ADDR-1:PAGE] as table PPN, set level=LEVELS-1, go to RD_REQ.
REQ-008 SHALL, in RD_REQ, drive mem_rd_valid=1 and mem_rd_addr={table_ppn, va[PAGE+9*level+8 : PAGE+9*level], 3'b000}; mem_rd_addr SHALL be held stable until mem_rd_ready; on handshake go to RD_WAIT.
REQ-009 SHALL, in RD_WAIT, ignore nothing but wait for mem_rsp_valid; one outstanding read maximum.
REQ-010 SHALL decode the PTE: bit0 present, bit7 leaf (PS), bits[ADDR-1:PAGE] next PPN.
REQ-011 SHALL, on PTE with present=0 at any level, set fill_fault=1, fill_ppn=0, go to FILL.
REQ-012 SHALL, at level 0 with present=1, set fill_ppn=pte[ADDR-1:PAGE], fill_fault=0, go to FILL.
REQ-013 SHALL, at level>0 with present=1 and PS=0, set table_ppn=pte[ADDR-1:PAGE], decrement level, go to RD_REQ.
REQ-014 SHALL handle PS=1 at level>0 per REQ-021/REQ-022; PS at level 0 SHALL be ignored.
REQ-015 SHALL hold fill_valid=1 with stable fill_* in FILL until fill_ready; on handshake return to IDLE; the next request is accepted no earlier than the following cycle.
REQ-016 SHALL take 2 cycles per level minimum (RD_REQ+RD_WAIT with zero-latency memory) plus 1 FILL cycle; full 4-level walk = 9 cycles from accept to fill handshake with ready-high memory and TLB.
REQ-017 SHALL drop mem_rsp_valid pulses arriving outside RD_WAIT.

Reset
REQ-018 SHALL, on rst_n=0 (asynchronous, including mid-walk), enter IDLE and clear level, table_ppn and latched request.
REQ-019 SHALL drive after reset: req_ready=1 (once rst_n high), mem_rd_valid=0, mem_rd_addr=0, fill_valid=0, fill_vpn=0, fill_pcid=0, fill_ppn=0, fill_fault=0.
REQ-020 SHALL abandon an in-flight read on reset; a late mem_rsp_valid is dropped per REQ-017.

Configuration
REQ-021 SHALL, with macro PTW_SUPERPAGE_EN defined, treat PS=1 at level L>0 as leaf: fill_ppn={pte[ADDR-1:PAGE+9*L], va[PAGE+9*L-1:PAGE]}, fill_fault=0.
REQ-022 SHALL, without PTW_SUPERPAGE_EN, treat PS=1 at level>0 as fault (fill_fault=1, fill_ppn=0).

Verification
REQ-023 4-level walk: ptbr=0x1000, va=0x403ABC, PTEs @0x1000=0x2001, @0x2000=0x3001, @0x3010=0x4001, @0x4018=0x99001 -> reads at 0x1000,0x2000,0x3010,0x4018; fill_ppn=0x99, fault=0, 9 cycles.
REQ-024 Non-present: same setup, PTE @0x3010=0x4000 -> 3 reads, fill_fault=1, fill_ppn=0.
REQ-025 Superpage: PTE @0x3010=0x200081 -> with PTW_SUPERPAGE_EN fill_ppn=0x203, fault=0; without it fault=1, ppn=0; 3 reads both cases.
REQ-026 Backpressure: mem_rd_ready low 5 cycles, fill_ready low 3 cycles -> mem_rd_addr and fill_* stable throughout; req_ready low until fill handshake.
REQ-027 Reset mid-walk: rst_n low while in RD_WAIT, then stray mem_rsp_valid after release -> IDLE, all outputs per REQ-019, no fill_valid.
